// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the MEM-stage load/store unit:
//   - RISC-V funct3 encodings for loads and stores
//   - the LSU FSM state type
//   - size_bytes(): access width in bytes for a funct3 code
package lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // The low two funct3 bits encode log2 of the access size for loads
  // and stores alike; bit 2 only selects zero-extension.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    logic [3:0] sz;
    case (f3[1:0])
      2'b00:   sz = 4'd1;
      2'b01:   sz = 4'd2;
      2'b10:   sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align
//   Combinational load extractor. Shifts the addressed bytes of the
//   returned memory word down to bit 0 and sign- or zero-extends them
//   according to the load funct3.
// Ports:
//   rdata      in   XLEN    raw word from data memory
//   offset     in   OFF_W   byte offset of the access within the word
//   funct3     in   3       load size/signedness
//   load_data  out  XLEN    extended result
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  load_data
);

  logic [XLEN-1:0] shifted;

  // Casting a $signed slice up to XLEN performs the sign extension, which
  // also keeps LW legal when XLEN is 32 (no zero-width replication).
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   load_data = XLEN'($signed(shifted[7:0]));
      F3_LH:   load_data = XLEN'($signed(shifted[15:0]));
      F3_LW:   load_data = XLEN'($signed(shifted[31:0]));
      F3_LBU:  load_data = XLEN'(shifted[7:0]);
      F3_LHU:  load_data = XLEN'(shifted[15:0]);
      F3_LWU:  load_data = XLEN'(shifted[31:0]);
      F3_LD:   load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Load/store unit for the MEM stage of the 5-stage RISC-V pipeline.
//   Converts EX/MEM load/store control into a req/ready data-memory
//   transaction, produces byte-lane enables and lane-replicated store
//   data, extracts and extends load data, and stalls the pipeline until
//   the access completes or times out.
//
//   Build option: define MISALIGN_TRAP_EN to trap misaligned accesses
//   (no memory request, one-cycle misalign pulse). Without it, misalign
//   stays 0 and the address is rounded down to the access size.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   mem_read/write    load/store request from EX/MEM (both = store)
//   funct3            access size/signedness
//   alu_out_addr      effective byte address
//   rs2_data          store data, LSB aligned
//   stall             freeze IF..EX/MEM while high (combinational)
//   load_data         extended load result, valid with load_valid
//   load_valid        one-cycle pulse, load result ready
//   bus_err           one-cycle pulse, timeout or unsupported funct3
//   misalign          one-cycle pulse, misaligned access (trap build only)
//   dm_req/we/addr/wdata/byte_en   data-memory request, held until dm_ready
//   dm_ready, dm_rdata             data-memory handshake and read data
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_out_addr,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              stall,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              bus_err,
  output logic              misalign,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN/8-1:0] dm_byte_en,
  input  logic              dm_ready,
  input  logic [XLEN-1:0]   dm_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam bit TIMEOUT_EN = (MAX_WAIT != 0);
  // Value held by the counter during the last BUSY cycle before abort.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [XLEN-1:0]   dm_wdata_q, dm_wdata_d;
  logic [NB-1:0]     dm_byte_en_q, dm_byte_en_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;

  logic              op_present;
  logic              supported;
  logic [OFF_W-1:0]  off_raw;
  logic [OFF_W-1:0]  size_mask;
  logic [OFF_W-1:0]  off_aligned;
  logic [NB-1:0]     byte_en_new;
  logic [XLEN-1:0]   wdata_new;
  logic [XLEN-1:0]   load_ext;

  lsu_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata     (dm_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .load_data (load_ext)
  );

  assign op_present = mem_read | mem_write;
  assign stall      = ((state_q == LSU_IDLE) && op_present) || (state_q == LSU_BUSY);

  // Decode of the incoming request: lane enables, replicated write data
  // and whether funct3 is legal for this XLEN. A simultaneous read and
  // write is decoded as a store.
  always_comb begin
    off_raw     = alu_out_addr[OFF_W-1:0];
    size_mask   = OFF_W'(size_bytes(funct3) - 4'd1);
    off_aligned = off_raw & ~size_mask;

    case (funct3[1:0])
      2'b00: begin
        byte_en_new = NB'(1) << off_aligned;
        wdata_new   = {NB{rs2_data[7:0]}};
      end
      2'b01: begin
        byte_en_new = NB'(3) << off_aligned;
        wdata_new   = {(NB/2){rs2_data[15:0]}};
      end
      2'b10: begin
        byte_en_new = NB'(15) << off_aligned;
        wdata_new   = {(NB/4){rs2_data[31:0]}};
      end
      default: begin
        byte_en_new = '1;
        wdata_new   = rs2_data;
      end
    endcase

    supported = 1'b0;
    if (mem_write) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: supported = 1'b1;
        F3_SD:               supported = (XLEN == 64);
        default:             supported = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: supported = 1'b1;
        F3_LD, F3_LWU:                       supported = (XLEN == 64);
        default:                             supported = 1'b0;
      endcase
    end
  end

  // Next-state logic. Pulse outputs and load_data default to 0 so they
  // are only non-zero in the DONE cycle; request outputs default to
  // holding their value so they stay stable through BUSY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    dm_byte_en_d = dm_byte_en_q;
    load_data_d  = '0;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    misalign_d   = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (op_present) begin
          f3_d  = funct3;
          off_d = off_aligned;
          if (!supported) begin
            bus_err_d = 1'b1;
            state_d   = LSU_DONE;
          end
`ifdef MISALIGN_TRAP_EN
          else if ((off_raw & size_mask) != '0) begin
            misalign_d = 1'b1;
            state_d    = LSU_DONE;
          end
`endif
          else begin
            dm_req_d     = 1'b1;
            dm_we_d      = mem_write;
            dm_addr_d    = {alu_out_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dm_wdata_d   = wdata_new;
            dm_byte_en_d = byte_en_new;
            state_d      = LSU_BUSY;
          end
        end
      end

      // dm_ready wins over the timeout when both occur in the same cycle.
      LSU_BUSY: begin
        if (dm_ready) begin
          dm_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = LSU_DONE;
          if (!dm_we_q) begin
            load_valid_d = 1'b1;
            load_data_d  = load_ext;
          end
        end else if (TIMEOUT_EN && (cnt_q == LAST_CNT)) begin
          dm_req_d  = 1'b0;
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = LSU_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      LSU_DONE: begin
        state_d = LSU_IDLE;
      end

      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_byte_en_q <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_byte_en_q <= dm_byte_en_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      misalign_q   <= misalign_d;
    end
  end

  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_byte_en = dm_byte_en_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//   Directed self-checking bench for mem_stage_lsu (XLEN=32, MAX_WAIT=16).
//   Honours MISALIGN_TRAP_EN for the misaligned-word case.
module tb_mem_stage_lsu;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out_addr;
  logic [31:0] rs2_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        misalign;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byte_en;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  int checks_total;
  int checks_failed;
  int busy_cycles;

  mem_stage_lsu #(
    .XLEN     (32),
    .ADDR_W   (32),
    .MAX_WAIT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .alu_out_addr (alu_out_addr),
    .rs2_data     (rs2_data),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .bus_err      (bus_err),
    .misalign     (misalign),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_byte_en   (dm_byte_en),
    .dm_ready     (dm_ready),
    .dm_rdata     (dm_rdata)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_total++;
    if (observed !== expected) begin
      checks_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the EX/MEM-side inputs
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data);
    mem_read     = rd;
    mem_write    = wr;
    funct3       = f3;
    alu_out_addr = addr;
    rs2_data     = data;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Full access with dm_ready already high: IDLE (stall) -> BUSY -> DONE
  task automatic doAccess(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_valid,
                          input logic [31:0] exp_load);
    dm_ready = 1'b1;
    dm_rdata = rdata;
    applyStimulus(rd, wr, f3, addr, data);
    #1;
    checkOutput({tag, ".stall_idle"}, 64'(stall), 64'd1);
    nextCycle();
    checkOutput({tag, ".dm_req"}, 64'(dm_req), 64'd1);
    checkOutput({tag, ".dm_we"}, 64'(dm_we), 64'(wr));
    checkOutput({tag, ".dm_addr"}, 64'(dm_addr), 64'(exp_addr));
    checkOutput({tag, ".byte_en"}, 64'(dm_byte_en), 64'(exp_be));
    if (wr) checkOutput({tag, ".wdata"}, 64'(dm_wdata), 64'(exp_wdata));
    checkOutput({tag, ".stall_busy"}, 64'(stall), 64'd1);
    nextCycle();
    checkOutput({tag, ".stall_done"}, 64'(stall), 64'd0);
    checkOutput({tag, ".dm_req_done"}, 64'(dm_req), 64'd0);
    checkOutput({tag, ".load_valid"}, 64'(load_valid), 64'(exp_valid));
    checkOutput({tag, ".load_data"}, 64'(load_data), 64'(exp_valid ? exp_load : 32'h0));
    checkOutput({tag, ".bus_err"}, 64'(bus_err), 64'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    checkOutput({tag, ".pulse_clear"}, 64'(load_valid), 64'd0);
  endtask

  initial begin
    checks_total  = 0;
    checks_failed = 0;
    rst           = 1'b1;
    dm_ready      = 1'b0;
    dm_rdata      = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Reset state
    nextCycle();
    nextCycle();
    checkOutput("reset.dm_req", 64'(dm_req), 64'd0);
    checkOutput("reset.stall", 64'(stall), 64'd0);
    checkOutput("reset.byte_en", 64'(dm_byte_en), 64'd0);
    checkOutput("reset.pulses", 64'({load_valid, bus_err, misalign}), 64'd0);
    checkOutput("reset.load_data", 64'(load_data), 64'd0);
    rst = 1'b0;
    nextCycle();

    // Stores
    doAccess("sw", 1'b0, 1'b1, SW, 32'h100, 32'hDEADBEEF, 32'h0,
             32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    doAccess("sb", 1'b0, 1'b1, SB, 32'h103, 32'hAABBCC12, 32'h0,
             32'h100, 4'b1000, 32'h12121212, 1'b0, 32'h0);
    doAccess("sh", 1'b0, 1'b1, SH, 32'h102, 32'h1234BEEF, 32'h0,
             32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0);
    doAccess("rd_wr_is_store", 1'b1, 1'b1, SW, 32'h104, 32'h00000055, 32'hFFFFFFFF,
             32'h104, 4'hF, 32'h00000055, 1'b0, 32'h0);

    // Loads
    doAccess("lb", 1'b1, 1'b0, LB, 32'h101, 32'h0, 32'h00008000,
             32'h100, 4'b0010, 32'h0, 1'b1, 32'hFFFFFF80);
    doAccess("lbu", 1'b1, 1'b0, LBU, 32'h101, 32'h0, 32'h00008000,
             32'h100, 4'b0010, 32'h0, 1'b1, 32'h00000080);
    doAccess("lh", 1'b1, 1'b0, LH, 32'h202, 32'h0, 32'h80010000,
             32'h200, 4'b1100, 32'h0, 1'b1, 32'hFFFF8001);
    doAccess("lhu", 1'b1, 1'b0, LHU, 32'h202, 32'h0, 32'h80010000,
             32'h200, 4'b1100, 32'h0, 1'b1, 32'h00008001);
    doAccess("lw", 1'b1, 1'b0, LW, 32'h300, 32'h0, 32'h89ABCDEF,
             32'h300, 4'hF, 32'h0, 1'b1, 32'h89ABCDEF);

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    dm_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, LW, 32'h102, 32'h0);
    #1;
    checkOutput("mis.stall_idle", 64'(stall), 64'd1);
    nextCycle();
    checkOutput("mis.dm_req", 64'(dm_req), 64'd0);
    checkOutput("mis.misalign", 64'(misalign), 64'd1);
    checkOutput("mis.load_valid", 64'(load_valid), 64'd0);
    checkOutput("mis.load_data", 64'(load_data), 64'd0);
    checkOutput("mis.stall_done", 64'(stall), 64'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    checkOutput("mis.pulse_clear", 64'(misalign), 64'd0);
`else
    doAccess("lw_round", 1'b1, 1'b0, LW, 32'h102, 32'h0, 32'h11223344,
             32'h100, 4'hF, 32'h0, 1'b1, 32'h11223344);
    checkOutput("lw_round.misalign", 64'(misalign), 64'd0);
`endif

    // Unsupported funct3 (LD with XLEN=32): no request, bus error
    applyStimulus(1'b1, 1'b0, LD, 32'h400, 32'h0);
    #1;
    checkOutput("unsup.stall_idle", 64'(stall), 64'd1);
    nextCycle();
    checkOutput("unsup.dm_req", 64'(dm_req), 64'd0);
    checkOutput("unsup.bus_err", 64'(bus_err), 64'd1);
    checkOutput("unsup.load_valid", 64'(load_valid), 64'd0);
    checkOutput("unsup.stall_done", 64'(stall), 64'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    checkOutput("unsup.pulse_clear", 64'(bus_err), 64'd0);

    // Timeout: dm_ready held low for the whole access
    dm_ready = 1'b0;
    dm_rdata = 32'hCAFEF00D;
    applyStimulus(1'b1, 1'b0, LW, 32'h500, 32'h0);
    nextCycle();
    busy_cycles = 0;
    while (dm_req && busy_cycles < 40) begin
      checkOutput("tmo.bus_err_early", 64'(bus_err), 64'd0);
      busy_cycles++;
      nextCycle();
    end
    checkOutput("tmo.busy_cycles", 64'(busy_cycles), 64'd16);
    checkOutput("tmo.bus_err", 64'(bus_err), 64'd1);
    checkOutput("tmo.stall_done", 64'(stall), 64'd0);
    checkOutput("tmo.load_data", 64'(load_data), 64'd0);
    checkOutput("tmo.load_valid", 64'(load_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    checkOutput("tmo.pulse_once", 64'(bus_err), 64'd0);

    // Ready arriving in the 16th BUSY cycle still completes normally
    dm_ready = 1'b0;
    dm_rdata = 32'h0000007F;
    applyStimulus(1'b1, 1'b0, LB, 32'h600, 32'h0);
    nextCycle();
    repeat (15) nextCycle();
    checkOutput("late.dm_req", 64'(dm_req), 64'd1);
    dm_ready = 1'b1;
    nextCycle();
    checkOutput("late.load_valid", 64'(load_valid), 64'd1);
    checkOutput("late.load_data", 64'(load_data), 64'h7F);
    checkOutput("late.bus_err", 64'(bus_err), 64'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();

    // Reset during BUSY abandons the access
    dm_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, LW, 32'h700, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("rstbusy.dm_req_before", 64'(dm_req), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    checkOutput("rstbusy.dm_req", 64'(dm_req), 64'd0);
    checkOutput("rstbusy.stall", 64'(stall), 64'd0);
    checkOutput("rstbusy.pulses", 64'({load_valid, bus_err, misalign}), 64'd0);
    rst = 1'b0;
    nextCycle();
    checkOutput("rstbusy.no_late_pulse", 64'({load_valid, bus_err}), 64'd0);
    doAccess("after_rst", 1'b1, 1'b0, LBU, 32'h803, 32'h0, 32'hA5000000,
             32'h800, 4'b1000, 32'h0, 1'b1, 32'h000000A5);

    $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
    $finish;
  end

  // Hard time limit so the bench always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
